simple_err_calc: RTL and testbench
==================================

# simple_err_calc

Error-calculation stage that sits directly downstream of the expected-value memory wrapper (`simple_err_expect`, 64 × 32-bit). For each element of an output vector it reads the expected word over the memory read port and subtracts it from the network output sample with saturation. It streams the signed error words to the back-propagation path and accumulates a sum of absolute errors that is reported at end of vector.

## Interface
Parameters:
- WIDTH, 32, data width of samples, expected words and error words
- ADDR_WIDTH, 6, expected-memory address width; maximum vector length is 2^ADDR_WIDTH = 64

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers
- start  in  1  single-cycle pulse; starts a vector pass (sampled only in IDLE)
- vec_len  in  ADDR_WIDTH+1  vector length, 0..64; sampled on the accepted start
- exp_rd_en  out  1  read strobe to the expected memory
- exp_rd_addr  out  ADDR_WIDTH  read address
- exp_rd_data  in  WIDTH  read data; valid exactly 1 cycle after exp_rd_en
- in_valid  in  1  network output sample valid
- in_data  in  WIDTH  sample, signed two's complement
- in_ready  out  1  sample accepted when in_valid && in_ready
- err_valid  out  1  error word valid (registered)
- err_data  out  WIDTH  signed saturated error, in_data − expected
- err_last  out  1  marks the final element of the vector
- err_ready  in  1  downstream accept
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of pass
- err_sum  out  WIDTH+ADDR_WIDTH  unsigned sum of absolute errors for the last completed pass

## Operation
- FSM states:
  - IDLE: busy=0. On start with vec_len≠0: capture len, clear idx and err_sum, drive exp_rd_en=1 with exp_rd_addr=0 in the same cycle, go to FETCH. On start with vec_len=0: clear err_sum, pulse done on the next cycle, stay in IDLE. start in any other state is ignored.
  - FETCH: register exp_rd_data into exp_q, go to READY.
  - READY: in_ready = !err_valid || err_ready. On an input handshake:
    - Register err_data = sat(in_data − exp_q), set err_valid=1, set err_last = (idx == len−1), and add |err_data| to err_sum.
    - If not last: idx++, drive exp_rd_en=1 with exp_rd_addr=idx+1 combinationally in the handshake cycle, go to FETCH.
    - If last: go to FLUSH.
  - FLUSH: when err_valid && err_ready, go to IDLE and pulse done on the next cycle.
- err_valid clears on err_ready unless a new word is loaded in the same cycle. err_data and err_last hold stable while err_valid && !err_ready.
- Arithmetic:
  - The difference is computed at WIDTH+1 bits and clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - The absolute value of the clamped result is taken as WIDTH-bit unsigned, so |−2^31| = 2^31.
  - err_sum cannot overflow: 64·2^31 < 2^38.
- exp_rd_en is high only in the two cases above. At most one read is outstanding, and it is never issued while in FETCH.
- err_sum holds its final value after done until the next accepted start.

## Timing
- Reset values: FSM=IDLE; in_ready, exp_rd_en, err_valid, err_last, busy, done = 0; exp_rd_addr, err_data, err_sum = 0.
- Start accepted in cycle 0: read issued in cycle 0, exp_q loaded at the end of cycle 1, in_ready can first assert in cycle 2.
- Handshake in cycle k: err_valid is high from cycle k+1; the next in_ready is no earlier than cycle k+2. Peak throughput is 1 sample per 2 cycles.
- done asserts in the cycle after the last err word is accepted. busy drops in the same cycle that done asserts.
- Reset asserted mid-pass: outputs return to reset values immediately (asynchronous). Any outstanding read data is discarded. The next start begins again at address 0.

## Test plan
- Basic: vec_len=4, mem={10,20,30,40}, in={15,20,25,−40}, err_ready=1 → err={5,0,−5,−80}, err_last only on the 4th word, err_sum=90, one done pulse, addresses 0..3 read once each.
- Saturation: mem[0]=0x80000000 with in=0x7FFFFFFF → err=0x7FFFFFFF; mem[1]=1 with in=0x80000000 → err=0x80000000; err_sum=0xFFFFFFFF.
- Backpressure: err_ready held low 5 cycles after the first err word → err_data/err_last stable, in_ready=0, no exp_rd_en; on release, the pass completes with correct values.
- Lengths: vec_len=0 → done in cycle 1, err_sum=0, no reads. vec_len=64 → addresses 0..63 in order, err_last on the 64th word.
- Reset mid-pass after 2 of 4 samples → all outputs 0 and busy=0 while reset is high; a new start with vec_len=2 reads addresses 0 and 1 and produces correct errors.
- start pulsed while busy → ignored; len, idx and err_sum are unaffected, and only one done pulse is produced.

Source files
------------

// File: rtl/simple_err_calc.sv
// simple_err_calc: saturating error stage between the expected-value
// memory and the back-prop path; streams errors and sums |error|.
module simple_err_calc #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_WIDTH:0]         vec_len,
  output logic                        exp_rd_en,
  output logic [ADDR_WIDTH-1:0]       exp_rd_addr,
  input  logic [WIDTH-1:0]            exp_rd_data,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ready,
  output logic                        err_valid,
  output logic [WIDTH-1:0]            err_data,
  output logic                        err_last,
  input  logic                        err_ready,
  output logic                        busy,
  output logic                        done,
  output logic [WIDTH+ADDR_WIDTH-1:0] err_sum
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]            state;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH-1:0] idx;
  logic [WIDTH-1:0]      exp_q;

  logic            in_hs;
  logic            is_last;
  logic            start_ok;
  logic            start_zero;
  logic [WIDTH:0]  diff;
  logic [WIDTH-1:0] sat_err;
  logic [WIDTH-1:0] abs_err;

  assign busy       = (state != S_IDLE);
  assign in_ready   = (state == S_READY) && (!err_valid || err_ready);
  assign in_hs      = in_valid && in_ready;
  assign is_last    = ({1'b0, idx} == (len - (ADDR_WIDTH+1)'(1)));
  assign start_ok   = (state == S_IDLE) && start && (vec_len != '0);
  assign start_zero = (state == S_IDLE) && start && (vec_len == '0);

  // One extra bit keeps the raw difference exact before clamping.
  assign diff = {in_data[WIDTH-1], in_data} - {exp_q[WIDTH-1], exp_q};

  always_comb begin
    sat_err = diff[WIDTH-1:0];
    if (diff[WIDTH] != diff[WIDTH-1]) begin
      sat_err = diff[WIDTH] ? MAX_NEG : MAX_POS;
    end
    abs_err = sat_err[WIDTH-1] ? (~sat_err + WIDTH'(1)) : sat_err;
  end

  always_comb begin
    exp_rd_en   = 1'b0;
    exp_rd_addr = '0;
    if (start_ok) begin
      exp_rd_en = 1'b1;
    end else if (in_hs && !is_last) begin
      exp_rd_en   = 1'b1;
      exp_rd_addr = idx + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      len       <= '0;
      idx       <= '0;
      exp_q     <= '0;
      err_valid <= 1'b0;
      err_data  <= '0;
      err_last  <= 1'b0;
      err_sum   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (in_hs) begin
        err_valid <= 1'b1;
        err_data  <= sat_err;
        err_last  <= is_last;
        err_sum   <= err_sum + {{ADDR_WIDTH{1'b0}}, abs_err};
      end else if (err_ready) begin
        err_valid <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            len     <= vec_len;
            idx     <= '0;
            err_sum <= '0;
            state   <= S_FETCH;
          end else if (start_zero) begin
            err_sum <= '0;
            done    <= 1'b1;
          end
        end
        S_FETCH: begin
          exp_q <= exp_rd_data;
          state <= S_READY;
        end
        S_READY: begin
          if (in_hs) begin
            if (is_last) begin
              state <= S_FLUSH;
            end else begin
              idx   <= idx + ADDR_WIDTH'(1);
              state <= S_FETCH;
            end
          end
        end
        S_FLUSH: begin
          if (err_valid && err_ready) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_err_calc.sv
// tb_simple_err_calc: randomized bench for simple_err_calc with an
// arithmetic reference model and a behavioural expected memory.
module tb_simple_err_calc;

  localparam int W  = 32;
  localparam int AW = 6;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   vec_len;
  logic          exp_rd_en;
  logic [AW-1:0] exp_rd_addr;
  logic [W-1:0]  exp_rd_data = '0;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          err_valid;
  logic [W-1:0]  err_data;
  logic          err_last;
  logic          err_ready;
  logic          busy;
  logic          done;
  logic [W+AW-1:0] err_sum;

  logic [W-1:0]  mem    [64];
  logic [W-1:0]  in_vec [64];
  logic [W-1:0]  exp_e  [64];
  logic [W+AW-1:0] exp_sum;

  logic [W-1:0] got_err [$];
  bit           got_last[$];
  int           rd_q    [$];
  int done_cnt, done_cyc, last_acc_cyc, start_cyc, first_rdy_cyc;
  bit busy_at_done, rdy_seen;
  int cyc_n = 0;
  int checks = 0;
  int errors = 0;
  bit stop;

  always #5 clk = ~clk;

  simple_err_calc #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .vec_len(vec_len),
    .exp_rd_en(exp_rd_en), .exp_rd_addr(exp_rd_addr),
    .exp_rd_data(exp_rd_data), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .err_valid(err_valid),
    .err_data(err_data), .err_last(err_last), .err_ready(err_ready),
    .busy(busy), .done(done), .err_sum(err_sum)
  );

  always @(posedge clk) begin
    if (exp_rd_en) exp_rd_data <= mem[exp_rd_addr];
    cyc_n <= cyc_n + 1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (err_valid && err_ready) begin
        got_err.push_back(err_data);
        got_last.push_back(err_last);
        if (err_last) last_acc_cyc = cyc_n;
      end
      if (exp_rd_en) rd_q.push_back(int'(exp_rd_addr));
      if (done) begin
        done_cnt++;
        done_cyc = cyc_n;
        busy_at_done = busy;
      end
      if (start && !busy) begin
        start_cyc = cyc_n;
        rdy_seen = 1'b0;
      end
      if (in_ready && !rdy_seen) begin
        rdy_seen = 1'b1;
        first_rdy_cyc = cyc_n;
      end
    end
  end

  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return W'($urandom_range(0, 200)) - 32'd100;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_pass(input int n);
    longint d;
    exp_sum = '0;
    for (int i = 0; i < n; i++) begin
      d = longint'($signed(in_vec[i])) - longint'($signed(mem[i]));
      if (d > MAXV) d = MAXV;
      if (d < MINV) d = MINV;
      exp_e[i] = d[31:0];
      exp_sum += (W+AW)'(d < 0 ? -d : d);
    end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      mem[i] = rnd_word();
      in_vec[i] = rnd_word();
    end
  endtask

  task automatic drive_pass(input int n, input int feed,
                            input bit wait_done, input bit gaps,
                            output bit to);
    int k = 0;
    int cyc = 0;
    int d0 = done_cnt;
    to = 1'b0;
    vec_len = (AW+1)'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (k < feed && cyc < 2000) begin
      in_valid = !(gaps && ($urandom_range(0, 2) == 0));
      in_data = in_vec[k];
      @(negedge clk);
      if (in_valid && in_ready) k++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc++;
    end
    if (k < feed) to = 1'b1;
    if (wait_done) begin
      while (done_cnt == d0 && cyc < 2000) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (done_cnt == d0) to = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, exp_rd_en, err_valid, err_last, busy, done,
         exp_rd_addr, err_data, err_sum} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b sum=%h want all 0",
               busy, done, err_sum);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int be = got_err.size();
    int br = rd_q.size();
    int bd = done_cnt;
    bit to;
    mem[0] = 10; mem[1] = 20; mem[2] = 30; mem[3] = 40;
    in_vec[0] = 15; in_vec[1] = 20; in_vec[2] = 25;
    in_vec[3] = 32'hFFFF_FFD8;
    exp_e[0] = 5; exp_e[1] = 0;
    exp_e[2] = 32'hFFFF_FFFB; exp_e[3] = 32'hFFFF_FFB0;
    drive_pass(4, 4, 1, 0, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout"); end
    checks++;
    if (got_err.size() - be != 4) begin
      errors++;
      $display("FAIL basic_count got=%0d want=4", got_err.size() - be);
    end
    for (int i = 0; i < 4 && be + i < got_err.size(); i++) begin
      checks++;
      if (got_err[be+i] !== exp_e[i] || got_last[be+i] !== (i == 3)) begin
        errors++;
        $display("FAIL basic_err[%0d] got=%h/%b want=%h/%b", i,
                 got_err[be+i], got_last[be+i], exp_e[i], i == 3);
      end
    end
    checks++;
    if (rd_q.size() - br != 4) begin
      errors++;
      $display("FAIL basic_reads got=%0d want=4", rd_q.size() - br);
    end
    for (int i = 0; i < 4 && br + i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[br+i] != i) begin
        errors++;
        $display("FAIL basic_addr[%0d] got=%0d want=%0d", i, rd_q[br+i], i);
      end
    end
    checks++;
    if (err_sum !== 38'd90) begin
      errors++;
      $display("FAIL basic_sum got=%0d want=90", err_sum);
    end
    checks++;
    if (done_cnt - bd != 1) begin
      errors++;
      $display("FAIL basic_done_cnt got=%0d want=1", done_cnt - bd);
    end
    checks++;
    if (first_rdy_cyc - start_cyc != 2) begin
      errors++;
      $display("FAIL basic_rdy_lat got=%0d want=2", first_rdy_cyc - start_cyc);
    end
    checks++;
    if (done_cyc - last_acc_cyc != 1 || busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_timing got=%0d/busy=%b want=1/busy=0",
               done_cyc - last_acc_cyc, busy_at_done);
    end
  endtask

  task automatic test_saturation();
    int be = got_err.size();
    bit to;
    mem[0] = 32'h8000_0000; in_vec[0] = 32'h7FFF_FFFF;
    mem[1] = 32'h0000_0001; in_vec[1] = 32'h8000_0000;
    drive_pass(2, 2, 1, 0, to);
    checks++;
    if (to || got_err.size() - be != 2) begin
      errors++;
      $display("FAIL sat_count got=%0d want=2", got_err.size() - be);
    end else begin
      checks++;
      if (got_err[be] !== 32'h7FFF_FFFF) begin
        errors++;
        $display("FAIL sat_pos got=%h want=7fffffff", got_err[be]);
      end
      checks++;
      if (got_err[be+1] !== 32'h8000_0000) begin
        errors++;
        $display("FAIL sat_neg got=%h want=80000000", got_err[be+1]);
      end
    end
    checks++;
    if (err_sum !== 38'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sat_sum got=%h want=ffffffff", err_sum);
    end
  endtask

  task automatic test_backpressure();
    int be = got_err.size();
    int bd = done_cnt;
    int wc = 0;
    bit to;
    logic [W-1:0] hd;
    logic hl;
    fill_rand(3);
    model_pass(3);
    err_ready = 1'b0;
    fork
      drive_pass(3, 3, 1, 0, to);
      begin
        @(negedge clk);
        while (!err_valid && wc < 50) begin
          @(negedge clk);
          wc++;
        end
        hd = err_data;
        hl = err_last;
        checks++;
        if (!err_valid || hd !== exp_e[0] || hl !== 1'b0) begin
          errors++;
          $display("FAIL bp_first got=%h/%b want=%h/0", hd, hl, exp_e[0]);
        end
        for (int c = 0; c < 5; c++) begin
          checks++;
          if (err_data !== hd || err_last !== hl ||
              in_ready !== 1'b0 || exp_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d] data=%h rdy=%b rd=%b want=%h/0/0",
                     c, err_data, in_ready, exp_rd_en, hd);
          end
          @(negedge clk);
        end
        @(posedge clk); #1;
        err_ready = 1'b1;
      end
    join
    checks++;
    if (to || got_err.size() - be != 3) begin
      errors++;
      $display("FAIL bp_count got=%0d want=3", got_err.size() - be);
    end
    for (int i = 0; i < 3 && be + i < got_err.size(); i++) begin
      checks++;
      if (got_err[be+i] !== exp_e[i] || got_last[be+i] !== (i == 2)) begin
        errors++;
        $display("FAIL bp_err[%0d] got=%h want=%h", i, got_err[be+i], exp_e[i]);
      end
    end
    checks++;
    if (err_sum !== exp_sum || done_cnt - bd != 1) begin
      errors++;
      $display("FAIL bp_sum got=%h want=%h", err_sum, exp_sum);
    end
  endtask

  task automatic test_lengths();
    int be = got_err.size();
    int br = rd_q.size();
    int bd = done_cnt;
    bit to;
    drive_pass(0, 0, 1, 0, to);
    checks++;
    if (to || done_cnt - bd != 1 || done_cyc - start_cyc != 1) begin
      errors++;
      $display("FAIL len0_done got=%0d@%0d want=1@1",
               done_cnt - bd, done_cyc - start_cyc);
    end
    checks++;
    if (err_sum !== '0 || rd_q.size() != br || got_err.size() != be) begin
      errors++;
      $display("FAIL len0_idle got sum=%h reads=%0d want 0/0",
               err_sum, rd_q.size() - br);
    end
    fill_rand(64);
    model_pass(64);
    bd = done_cnt;
    drive_pass(64, 64, 1, 1, to);
    checks++;
    if (to || got_err.size() - be != 64 || rd_q.size() - br != 64) begin
      errors++;
      $display("FAIL len64_count got=%0d/%0d want=64/64",
               got_err.size() - be, rd_q.size() - br);
    end
    for (int i = 0; i < 64 && be + i < got_err.size(); i++) begin
      checks++;
      if (got_err[be+i] !== exp_e[i] || got_last[be+i] !== (i == 63)) begin
        errors++;
        $display("FAIL len64_err[%0d] got=%h/%b want=%h", i,
                 got_err[be+i], got_last[be+i], exp_e[i]);
      end
    end
    for (int i = 0; i < 64 && br + i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[br+i] != i) begin
        errors++;
        $display("FAIL len64_addr[%0d] got=%0d want=%0d", i, rd_q[br+i], i);
      end
    end
    checks++;
    if (err_sum !== exp_sum || done_cnt - bd != 1) begin
      errors++;
      $display("FAIL len64_sum got=%h want=%h", err_sum, exp_sum);
    end
  endtask

  task automatic test_reset_mid_pass();
    int be, br;
    bit to;
    fill_rand(4);
    drive_pass(4, 2, 0, 0, to);
    #2;
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({in_ready, exp_rd_en, err_valid, err_last, busy, done,
           exp_rd_addr, err_data, err_sum} !== '0) begin
        errors++;
        $display("FAIL rst_mid[%0d] got busy=%b ev=%b sum=%h want 0",
                 c, busy, err_valid, err_sum);
      end
      @(posedge clk);
    end
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    fill_rand(2);
    model_pass(2);
    be = got_err.size();
    br = rd_q.size();
    drive_pass(2, 2, 1, 0, to);
    checks++;
    if (to || got_err.size() - be != 2 || rd_q.size() - br != 2) begin
      errors++;
      $display("FAIL rst_after_count got=%0d/%0d want=2/2",
               got_err.size() - be, rd_q.size() - br);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rd_q[br+i] != i || got_err[be+i] !== exp_e[i] ||
            got_last[be+i] !== (i == 1)) begin
          errors++;
          $display("FAIL rst_after[%0d] got=%0d:%h want=%0d:%h", i,
                   rd_q[br+i], got_err[be+i], i, exp_e[i]);
        end
      end
    end
    checks++;
    if (err_sum !== exp_sum) begin
      errors++;
      $display("FAIL rst_after_sum got=%h want=%h", err_sum, exp_sum);
    end
  endtask

  task automatic test_start_while_busy();
    int be = got_err.size();
    int br = rd_q.size();
    int bd = done_cnt;
    bit to;
    fill_rand(4);
    model_pass(4);
    fork
      drive_pass(4, 4, 1, 0, to);
      begin
        repeat (3) @(posedge clk);
        #2;
        start = 1'b1;
        vec_len = 7'd2;
        @(posedge clk); #2;
        start = 1'b0;
      end
    join
    checks++;
    if (to || got_err.size() - be != 4 || rd_q.size() - br != 4) begin
      errors++;
      $display("FAIL busy_start_count got=%0d/%0d want=4/4",
               got_err.size() - be, rd_q.size() - br);
    end
    for (int i = 0; i < 4 && be + i < got_err.size(); i++) begin
      checks++;
      if (got_err[be+i] !== exp_e[i] || got_last[be+i] !== (i == 3)) begin
        errors++;
        $display("FAIL busy_start_err[%0d] got=%h want=%h", i,
                 got_err[be+i], exp_e[i]);
      end
    end
    checks++;
    if (err_sum !== exp_sum || done_cnt - bd != 1) begin
      errors++;
      $display("FAIL busy_start_sum got=%h/%0d want=%h/1", err_sum,
               done_cnt - bd, exp_sum);
    end
  endtask

  task automatic test_random();
    int n, be, br, bd;
    bit to;
    for (int p = 0; p < 6; p++) begin
      n = $urandom_range(1, 64);
      fill_rand(n);
      model_pass(n);
      be = got_err.size();
      br = rd_q.size();
      bd = done_cnt;
      stop = 1'b0;
      fork
        begin
          drive_pass(n, n, 1, 1, to);
          stop = 1'b1;
        end
        while (!stop) begin
          err_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      join
      err_ready = 1'b1;
      checks++;
      if (to || got_err.size() - be != n || rd_q.size() - br != n) begin
        errors++;
        $display("FAIL rnd%0d_count got=%0d/%0d want=%0d", p,
                 got_err.size() - be, rd_q.size() - br, n);
      end
      for (int i = 0; i < n && be + i < got_err.size(); i++) begin
        checks++;
        if (got_err[be+i] !== exp_e[i] || got_last[be+i] !== (i == n-1)) begin
          errors++;
          $display("FAIL rnd%0d_err[%0d] got=%h want=%h", p, i,
                   got_err[be+i], exp_e[i]);
        end
      end
      for (int i = 0; i < n && br + i < rd_q.size(); i++) begin
        checks++;
        if (rd_q[br+i] != i) begin
          errors++;
          $display("FAIL rnd%0d_addr[%0d] got=%0d want=%0d", p, i,
                   rd_q[br+i], i);
        end
      end
      checks++;
      if (err_sum !== exp_sum || done_cnt - bd != 1) begin
        errors++;
        $display("FAIL rnd%0d_sum got=%h want=%h", p, err_sum, exp_sum);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    vec_len = '0;
    in_valid = 1'b0;
    in_data = '0;
    err_ready = 1'b1;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_lengths();
    test_reset_mid_pass();
    test_start_while_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
